uart_rx_fifo: RTL and testbench

Parametrised UART receiver with an integrated receive FIFO. It is the successor to the fixed 8N1 echo-path receiver on the board top.
- Generalises data bits, parity mode, baud divisor and buffer depth.
- Adds sticky framing, parity and overrun error flags.
- Sits between the board uart_rxd pin and the CPU's UART bridge device, which pops bytes by rd_en.

---
 rtl/uart_rx_fifo.sv | 186 ++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// UART receiver (configurable data bits / parity / baud divisor) feeding a
// first-word-fall-through receive FIFO with sticky framing, parity and overrun flags.
module uart_rx_fifo #(
    parameter int BAUD_DIV   = 5208,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk_in,
    input  logic                          sys_rstn,
    input  logic                          uart_rxd,
    input  logic                          rd_en,
    input  logic                          err_clr,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          rx_empty,
    output logic                          rx_full,
    output logic [$clog2(FIFO_DEPTH):0]   rx_count,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overrun
);
    localparam int CW = $clog2(BAUD_DIV);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int NW = AW + 1;
    localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
    } state_t;

    logic                 rxd_meta_q, rxd_s_q;
    state_t               state_q, state_d;
    logic [CW-1:0]        baud_q, baud_d;
    logic [3:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_bad_q, par_bad_d;
    logic                 push_q, push_d;
    logic                 fe_set, pe_set;

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_BITS-1:0] mem_d [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [NW-1:0]        count_q, count_d;
    logic                 fe_q, fe_d, pe_q, pe_d, ov_q, ov_d;
    logic                 do_pop, do_wr;

    // Receive FSM: every sample point is the edge where the baud counter hits its target.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        par_bad_d = par_bad_q;
        push_d    = 1'b0;
        fe_set    = 1'b0;
        pe_set    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!rxd_s_q) begin
                    baud_d  = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_q == HALF) begin
                    baud_d = '0;
                    if (rxd_s_q) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d   = S_DATA;
                        bit_d     = '0;
                        par_bad_d = 1'b0;
                    end
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            S_DATA: begin
                if (baud_q == LAST) begin
                    baud_d  = '0;
                    shift_d = {rxd_s_q, shift_q[DATA_BITS-1:1]};
                    bit_d   = bit_q + 4'd1;
                    if (bit_q == 4'(DATA_BITS - 1))
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            S_PARITY: begin
                if (baud_q == LAST) begin
                    baud_d    = '0;
                    par_bad_d = ((^shift_q) ^ rxd_s_q) != (PARITY == 1);
                    state_d   = S_STOP;
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            S_STOP: begin
                if (baud_q == LAST) begin
                    baud_d = '0;
                    if (!rxd_s_q) begin
                        fe_set  = 1'b1;
                        state_d = S_WAIT_HIGH;
                    end else begin
                        pe_set  = par_bad_q;
                        push_d  = !par_bad_q;
                        state_d = S_IDLE;
                    end
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            S_WAIT_HIGH: begin
                if (rxd_s_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A push into a full FIFO succeeds only when a pop frees the head slot this cycle.
    always_comb begin
        do_pop   = rd_en && (count_q != '0);
        do_wr    = push_q && ((count_q != NW'(FIFO_DEPTH)) || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_wr) begin
            mem_d[wr_ptr_q] = shift_q;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
        count_d = count_q + NW'(do_wr) - NW'(do_pop);

        fe_d = err_clr ? 1'b0 : fe_q;
        pe_d = err_clr ? 1'b0 : pe_q;
        ov_d = err_clr ? 1'b0 : ov_q;
        if (fe_set) fe_d = 1'b1;
        if (pe_set) pe_d = 1'b1;
        if (push_q && !do_wr) ov_d = 1'b1;
    end

    always_ff @(posedge clk_in or negedge sys_rstn) begin
        if (!sys_rstn) begin
            rxd_meta_q <= 1'b1;
            rxd_s_q    <= 1'b1;
            state_q    <= S_IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            par_bad_q  <= 1'b0;
            push_q     <= 1'b0;
            mem_q      <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            fe_q       <= 1'b0;
            pe_q       <= 1'b0;
            ov_q       <= 1'b0;
        end else begin
            rxd_meta_q <= uart_rxd;
            rxd_s_q    <= rxd_meta_q;
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            par_bad_q  <= par_bad_d;
            push_q     <= push_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            fe_q       <= fe_d;
            pe_q       <= pe_d;
            ov_q       <= ov_d;
        end
    end

    assign rx_empty   = (count_q == '0);
    assign rx_full    = (count_q == NW'(FIFO_DEPTH));
    assign rx_count   = count_q;
    assign rx_data    = rx_empty ? '0 : mem_q[rd_ptr_q];
    assign frame_err  = fe_q;
    assign parity_err = pe_q;
    assign overrun    = ov_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: an 8N1 depth-4 instance and an 8E1 depth-8 instance, checked
// against queue-based models of the frames the bench itself serialises.
module tb_uart_rx_fifo;
    localparam int BD = 4;

    logic clk_in = 1'b0, sys_rstn = 1'b0;
    always #5 clk_in = ~clk_in;

    logic rxd_n = 1'b1, rd_n = 1'b0, clr_n = 1'b0;
    logic rxd_e = 1'b1, rd_e = 1'b0, clr_e = 1'b0;
    logic [7:0] data_n, data_e;
    logic empty_n, full_n, fe_n, pe_n, ov_n;
    logic empty_e, full_e, fe_e, pe_e, ov_e;
    logic [2:0] cnt_n;
    logic [3:0] cnt_e;

    int pass = 0, tot = 0;
    logic [7:0] q_n [$];
    bit ov_m;

    uart_rx_fifo #(.BAUD_DIV(BD), .DATA_BITS(8), .PARITY(0), .FIFO_DEPTH(4)) u_n (
        .clk_in(clk_in), .sys_rstn(sys_rstn), .uart_rxd(rxd_n), .rd_en(rd_n), .err_clr(clr_n),
        .rx_data(data_n), .rx_empty(empty_n), .rx_full(full_n), .rx_count(cnt_n),
        .frame_err(fe_n), .parity_err(pe_n), .overrun(ov_n));

    uart_rx_fifo #(.BAUD_DIV(BD), .DATA_BITS(8), .PARITY(2), .FIFO_DEPTH(8)) u_e (
        .clk_in(clk_in), .sys_rstn(sys_rstn), .uart_rxd(rxd_e), .rd_en(rd_e), .err_clr(clr_e),
        .rx_data(data_e), .rx_empty(empty_e), .rx_full(full_e), .rx_count(cnt_e),
        .frame_err(fe_e), .parity_err(pe_e), .overrun(ov_e));

    task automatic drive(input int w, input logic b);
        if (w == 0) rxd_n = b; else rxd_e = b;
    endtask

    // One frame, each bit held BD cycles; line left at 'after', then two idle bit times.
    task automatic send(input int w, input logic [7:0] d, input bit hp, input bit pb,
                        input bit sb, input bit after);
        @(posedge clk_in); #1 drive(w, 1'b0);
        for (int i = 0; i < 8; i++) begin
            repeat (BD) @(posedge clk_in); #1 drive(w, d[i]);
        end
        if (hp) begin
            repeat (BD) @(posedge clk_in); #1 drive(w, pb);
        end
        repeat (BD) @(posedge clk_in); #1 drive(w, sb);
        repeat (BD) @(posedge clk_in); #1 drive(w, after);
        repeat (2 * BD) @(posedge clk_in); #1;
    endtask

    task automatic pop_n();
        rd_n = 1'b1; @(posedge clk_in); #1 rd_n = 1'b0;
    endtask

    task automatic pop_e();
        rd_e = 1'b1; @(posedge clk_in); #1 rd_e = 1'b0;
    endtask

    task automatic clear_n();
        clr_n = 1'b1; @(posedge clk_in); #1 clr_n = 1'b0;
    endtask

    task automatic clear_e();
        clr_e = 1'b1; @(posedge clk_in); #1 clr_e = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        tot++; if ({empty_n, full_n, cnt_n, data_n, fe_n, pe_n, ov_n} !== {1'b1, 1'b0, 3'd0, 8'h00, 3'b000})
            $display("FAIL reset_n got e%b f%b c%0d d%h flags%b%b%b", empty_n, full_n, cnt_n, data_n, fe_n, pe_n, ov_n);
        else pass++;
        tot++; if ({empty_e, full_e, cnt_e, data_e, fe_e, pe_e, ov_e} !== {1'b1, 1'b0, 4'd0, 8'h00, 3'b000})
            $display("FAIL reset_e got e%b f%b c%0d d%h flags%b%b%b", empty_e, full_e, cnt_e, data_e, fe_e, pe_e, ov_e);
        else pass++;
        @(posedge clk_in); #1 sys_rstn = 1'b1;
        repeat (4) @(posedge clk_in); #1;
    endtask

    task automatic test_basic();
        send(0, 8'h55, 0, 0, 1, 1);
        send(0, 8'hA3, 0, 0, 1, 1);
        tot++; if (cnt_n !== 3'd2) $display("FAIL basic_count got %0d exp 2", cnt_n); else pass++;
        tot++; if (data_n !== 8'h55) $display("FAIL basic_head got %h exp 55", data_n); else pass++;
        pop_n();
        tot++; if (data_n !== 8'hA3) $display("FAIL basic_second got %h exp a3", data_n); else pass++;
        pop_n();
        tot++; if ({empty_n, fe_n, pe_n, ov_n} !== 4'b1000)
            $display("FAIL basic_flags got empty%b flags%b%b%b exp 1 000", empty_n, fe_n, pe_n, ov_n);
        else pass++;
    endtask

    task automatic test_parity();
        send(1, 8'h07, 1, 1'b1, 1, 1);
        tot++; if ({cnt_e, data_e, pe_e} !== {4'd1, 8'h07, 1'b0})
            $display("FAIL par_good got c%0d d%h pe%b exp 1 07 0", cnt_e, data_e, pe_e);
        else pass++;
        send(1, 8'h07, 1, 1'b0, 1, 1);
        tot++; if ({cnt_e, pe_e} !== {4'd1, 1'b1})
            $display("FAIL par_bad got c%0d pe%b exp 1 1", cnt_e, pe_e);
        else pass++;
        clear_e();
        tot++; if (pe_e !== 1'b0) $display("FAIL par_clear got %b exp 0", pe_e); else pass++;
        pop_e();
    endtask

    task automatic test_framing();
        send(0, 8'h3C, 0, 0, 0, 0);
        repeat (20 * BD) @(posedge clk_in); #1;
        tot++; if ({fe_n, cnt_n} !== {1'b1, 3'd0})
            $display("FAIL frame_err got fe%b c%0d exp 1 0", fe_n, cnt_n);
        else pass++;
        rxd_n = 1'b1;
        repeat (2 * BD) @(posedge clk_in); #1;
        send(0, 8'h81, 0, 0, 1, 1);
        tot++; if ({cnt_n, data_n} !== {3'd1, 8'h81})
            $display("FAIL frame_recover got c%0d d%h exp 1 81", cnt_n, data_n);
        else pass++;
        pop_n();
        clear_n();
        tot++; if (fe_n !== 1'b0) $display("FAIL frame_clear got %b exp 0", fe_n); else pass++;
    endtask

    task automatic test_overrun();
        for (int i = 1; i <= 5; i++) send(0, 8'(i), 0, 0, 1, 1);
        tot++; if ({full_n, ov_n, cnt_n} !== {1'b1, 1'b1, 3'd4})
            $display("FAIL ovr_state got full%b ov%b c%0d exp 1 1 4", full_n, ov_n, cnt_n);
        else pass++;
        for (int i = 1; i <= 4; i++) begin
            tot++; if (data_n !== 8'(i)) $display("FAIL ovr_pop got %h exp %h", data_n, 8'(i)); else pass++;
            pop_n();
        end
        tot++; if (empty_n !== 1'b1) $display("FAIL ovr_empty got %b exp 1", empty_n); else pass++;
        clear_n();
    endtask

    // Stop bit of frame 5 is sampled 41 edges after the start-bit edge; the write lands on edge 42.
    task automatic test_back_to_back();
        for (int i = 1; i <= 4; i++) send(0, 8'(i), 0, 0, 1, 1);
        fork
            send(0, 8'h05, 0, 0, 1, 1);
            begin
                repeat (42) @(posedge clk_in);
                #1;
                tot++; if (data_n !== 8'h01) $display("FAIL b2b_head got %h exp 01", data_n); else pass++;
                rd_n = 1'b1; @(posedge clk_in); #1 rd_n = 1'b0;
            end
        join
        tot++; if ({ov_n, cnt_n, full_n} !== {1'b0, 3'd4, 1'b1})
            $display("FAIL b2b_state got ov%b c%0d full%b exp 0 4 1", ov_n, cnt_n, full_n);
        else pass++;
        for (int i = 2; i <= 5; i++) begin
            tot++; if (data_n !== 8'(i)) $display("FAIL b2b_pop got %h exp %h", data_n, 8'(i)); else pass++;
            pop_n();
        end
    endtask

    task automatic test_glitch_reset();
        @(posedge clk_in); #1 rxd_n = 1'b0;
        @(posedge clk_in); #1 rxd_n = 1'b1;
        repeat (12 * BD) @(posedge clk_in); #1;
        tot++; if ({cnt_n, fe_n, pe_n, ov_n} !== {3'd0, 3'b000})
            $display("FAIL glitch got c%0d flags%b%b%b exp 0 000", cnt_n, fe_n, pe_n, ov_n);
        else pass++;
        send(0, 8'h00, 0, 0, 0, 1);
        send(0, 8'h11, 0, 0, 1, 1);
        tot++; if ({cnt_n, fe_n} !== {3'd1, 1'b1})
            $display("FAIL pre_reset got c%0d fe%b exp 1 1", cnt_n, fe_n);
        else pass++;
        @(posedge clk_in); #1 rxd_n = 1'b0;
        repeat (14) @(posedge clk_in); #1 rxd_n = 1'b1;
        sys_rstn = 1'b0; #1;
        tot++; if ({empty_n, full_n, cnt_n, data_n, fe_n, pe_n, ov_n} !== {1'b1, 1'b0, 3'd0, 8'h00, 3'b000})
            $display("FAIL midframe_reset got e%b f%b c%0d d%h flags%b%b%b", empty_n, full_n, cnt_n, data_n, fe_n, pe_n, ov_n);
        else pass++;
        repeat (3) @(posedge clk_in); #1 sys_rstn = 1'b1;
        repeat (2 * BD) @(posedge clk_in); #1;
        send(0, 8'h5A, 0, 0, 1, 1);
        tot++; if ({cnt_n, data_n} !== {3'd1, 8'h5A})
            $display("FAIL after_reset got c%0d d%h exp 1 5a", cnt_n, data_n);
        else pass++;
        pop_n();
    endtask

    task automatic test_random_fifo();
        logic [7:0] b;
        q_n.delete();
        ov_m = 1'b0;
        clear_n();
        for (int k = 0; k < 14; k++) begin
            int np = $urandom_range(0, 2);
            for (int j = 0; j < np; j++) begin
                if (q_n.size() > 0) begin
                    tot++; if (data_n !== q_n[0]) $display("FAIL rnd_pop got %h exp %h", data_n, q_n[0]); else pass++;
                    void'(q_n.pop_front());
                    pop_n();
                end
            end
            b = 8'($urandom);
            send(0, b, 0, 0, 1, 1);
            if (q_n.size() < 4) q_n.push_back(b); else ov_m = 1'b1;
            tot++; if (cnt_n !== 3'(q_n.size())) $display("FAIL rnd_count got %0d exp %0d", cnt_n, q_n.size()); else pass++;
            tot++; if (ov_n !== ov_m) $display("FAIL rnd_overrun got %b exp %b", ov_n, ov_m); else pass++;
        end
        while (q_n.size() > 0) begin
            tot++; if (data_n !== q_n[0]) $display("FAIL rnd_drain got %h exp %h", data_n, q_n[0]); else pass++;
            void'(q_n.pop_front());
            pop_n();
        end
        tot++; if (empty_n !== 1'b1) $display("FAIL rnd_empty got %b exp 1", empty_n); else pass++;
    endtask

    task automatic test_random_parity();
        logic [7:0] b;
        bit good, pb;
        for (int k = 0; k < 8; k++) begin
            b    = 8'($urandom);
            good = 1'($urandom_range(0, 1));
            pb   = good ? (^b) : ~(^b);
            send(1, b, 1, pb, 1, 1);
            if (good) begin
                tot++; if ({cnt_e, data_e, pe_e} !== {4'd1, b, 1'b0})
                    $display("FAIL rndpar_good got c%0d d%h pe%b exp 1 %h 0", cnt_e, data_e, pe_e, b);
                else pass++;
                pop_e();
            end else begin
                tot++; if ({cnt_e, pe_e} !== {4'd0, 1'b1})
                    $display("FAIL rndpar_bad got c%0d pe%b exp 0 1", cnt_e, pe_e);
                else pass++;
                clear_e();
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_framing();
        test_overrun();
        test_back_to_back();
        test_glitch_reset();
        test_random_fifo();
        test_random_parity();
        $display("%0d/%0d checks passed", pass, tot);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout after %0d of %0d checks", pass, tot);
        $fatal(1);
    end
endmodule
